// File: rtl/regfile_block_transfer.sv
// Block register/memory transfer sequencer for the CHIP-8 FX55 (store V0..Vx
// to mem[I..I+x]) and FX65 (load V0..Vx from mem[I..I+x]) opcodes.
// Each register takes two cycles: XFER_A issues the read (register file or
// memory), XFER_B presents the returned data to the other side with a single
// write strobe. Strobes are decoded from the state register, so an
// asynchronous reset removes them immediately. Address and select outputs
// hold their last driven value between uses.
module regfile_block_transfer #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int INCREMENT_I = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  dir,
  input  logic [3:0]            last_reg,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] i_next,
  output logic [3:0]            rf_sel_out,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  rf_we,
  output logic [3:0]            rf_sel_in,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_XFER_A = 2'd1;
  localparam logic [1:0] S_XFER_B = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic INC_I = (INCREMENT_I != 0);

  logic [1:0]            state_q;
  logic [3:0]            k_q;
  logic                  dir_q;
  logic [3:0]            x_q;
  logic [ADDR_WIDTH-1:0] base_q;

  logic [3:0]            rf_sel_out_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [3:0]            rf_sel_in_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic [ADDR_WIDTH-1:0] i_next_q;

  logic                  accept;
  logic                  st_a;
  logic                  ld_a;
  logic                  st_b;
  logic                  ld_b;
  logic                  last_k;
  logic [ADDR_WIDTH-1:0] addr_k;
  logic [ADDR_WIDTH-1:0] i_next_calc;

  // Phase decode and address arithmetic (wraps at ADDR_WIDTH bits).
  always_comb begin
    accept      = (state_q == S_IDLE) && start;
    st_a        = (state_q == S_XFER_A) && !dir_q;
    ld_a        = (state_q == S_XFER_A) &&  dir_q;
    st_b        = (state_q == S_XFER_B) && !dir_q;
    ld_b        = (state_q == S_XFER_B) &&  dir_q;
    last_k      = (k_q == x_q);
    addr_k      = base_q + ADDR_WIDTH'(k_q);
    // In the final XFER_B k equals x, so addr_k + 1 is base + x + 1.
    i_next_calc = INC_I ? (addr_k + ADDR_WIDTH'(1)) : base_q;
  end

  // Sequencer state and per-register counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      k_q     <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_XFER_A;
            k_q     <= 4'd0;
          end
        end
        S_XFER_A: state_q <= S_XFER_B;
        S_XFER_B: begin
          if (last_k) begin
            state_q <= S_DONE;
          end else begin
            k_q     <= k_q + 4'd1;
            state_q <= S_XFER_A;
          end
        end
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Operation arguments, captured only when a start is accepted so that
  // input changes during a transfer are invisible.
  always_ff @(posedge clk) begin
    if (accept) begin
      dir_q  <= dir;
      x_q    <= last_reg;
      base_q <= base_addr;
    end
  end

  // Hold registers: remember the last driven address/select/data and I.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_sel_out_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rf_sel_in_q  <= '0;
      rf_wdata_q   <= '0;
      i_next_q     <= '0;
    end else begin
      if (st_a) begin
        rf_sel_out_q <= k_q;
      end
      if (ld_a || st_b) begin
        mem_addr_q <= addr_k;
      end
      if (st_b) begin
        mem_wdata_q <= rf_rdata;
      end
      if (ld_b) begin
        rf_sel_in_q <= k_q;
        rf_wdata_q  <= mem_rdata;
      end
      if ((state_q == S_XFER_B) && last_k) begin
        i_next_q <= i_next_calc;
      end
    end
  end

  // Output drive: live values during the owning phase, held values otherwise.
  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    i_next     = i_next_q;
    rf_sel_out = st_a ? k_q : rf_sel_out_q;
    mem_addr   = (ld_a || st_b) ? addr_k : mem_addr_q;
    mem_we     = st_b;
    mem_wdata  = st_b ? rf_rdata : mem_wdata_q;
    rf_we      = ld_b;
    rf_sel_in  = ld_b ? k_q : rf_sel_in_q;
    rf_wdata   = ld_b ? mem_rdata : rf_wdata_q;
  end

  // The two write ports must never be strobed in the same cycle.
  a_one_strobe: assert property (@(posedge clk) disable iff (!reset) !(rf_we && mem_we));

endmodule

// File: tb/tb_regfile_block_transfer.sv
// Bench for regfile_block_transfer: a register file and synchronous RAM
// surround the DUT, and a reference model derived from the operation rules
// (cycle number since accept, k = cycle/2, address = base + k mod 4096)
// checks every output every cycle. A second instance with INCREMENT_I = 0
// shares all inputs and is checked for the unchanged-I result.
module tb_regfile_block_transfer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        dir;
  logic [3:0]  last_reg;
  logic [11:0] base_addr;
  logic [7:0]  rf_rdata;
  logic [7:0]  mem_rdata;

  logic        busy, done, rf_we, mem_we;
  logic [11:0] i_next, mem_addr;
  logic [3:0]  rf_sel_out, rf_sel_in;
  logic [7:0]  rf_wdata, mem_wdata;

  logic        b1_busy, b1_done, b1_rf_we, b1_mem_we;
  logic [11:0] b1_i_next, b1_mem_addr;
  logic [3:0]  b1_rf_sel_out, b1_rf_sel_in;
  logic [7:0]  b1_rf_wdata, b1_mem_wdata;

  always #5 clk = ~clk;

  regfile_block_transfer #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .INCREMENT_I(1)) u0 (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .last_reg(last_reg),
    .base_addr(base_addr), .busy(busy), .done(done), .i_next(i_next),
    .rf_sel_out(rf_sel_out), .rf_rdata(rf_rdata), .rf_we(rf_we),
    .rf_sel_in(rf_sel_in), .rf_wdata(rf_wdata), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  regfile_block_transfer #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .INCREMENT_I(0)) u1 (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .last_reg(last_reg),
    .base_addr(base_addr), .busy(b1_busy), .done(b1_done), .i_next(b1_i_next),
    .rf_sel_out(b1_rf_sel_out), .rf_rdata(rf_rdata), .rf_we(b1_rf_we),
    .rf_sel_in(b1_rf_sel_in), .rf_wdata(b1_rf_wdata), .mem_addr(b1_mem_addr),
    .mem_we(b1_mem_we), .mem_wdata(b1_mem_wdata), .mem_rdata(mem_rdata));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Environment: V0..VF and main memory, both with one-cycle read latency.
  bit [7:0]  rf  [16];
  bit [7:0]  mem [4096];
  logic        pk_en = 1'b0;
  logic        pk_mem = 1'b0;
  logic [11:0] pk_a = '0;
  logic [7:0]  pk_d = '0;

  always @(posedge clk) begin
    rf_rdata  <= rf[rf_sel_out];
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (rf_we)  rf[rf_sel_in]  <= rf_wdata;
    if (pk_en) begin
      if (pk_mem) mem[pk_a] <= pk_d;
      else        rf[pk_a[3:0]] <= pk_d;
    end
  end

  // Reference model: operation tracking by cycle number since accept.
  bit          m_active = 1'b0;
  int          m_c = 0;
  bit          m_dir = 1'b0;
  int          m_x = 0;
  logic [11:0] m_base = '0;
  bit [7:0]    exp_rf  [16];
  bit [7:0]    exp_mem [4096];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_c      <= 1;
        m_dir    <= dir;
        m_x      <= int'(last_reg);
        m_base   <= base_addr;
      end
    end else if (m_c == 2 * m_x + 3) begin
      m_active <= 1'b0;
    end else begin
      m_c <= m_c + 1;
    end
  end

  // Compare process: every cycle out of reset, both instances vs the model.
  initial begin
    forever begin : cmp
      bit          e_a, e_b, e_d, e_mwe, e_rwe;
      int          k;
      logic [11:0] ea;
      @(negedge clk);
      if (pk_en) begin
        if (pk_mem) exp_mem[pk_a] = pk_d;
        else        exp_rf[pk_a[3:0]] = pk_d;
      end
      if (reset === 1'b1) begin
        e_a   = m_active && (m_c % 2 == 1) && (m_c <= 2 * m_x + 2);
        e_b   = m_active && (m_c % 2 == 0) && (m_c <= 2 * m_x + 2);
        e_d   = m_active && (m_c == 2 * m_x + 3);
        e_mwe = e_b && !m_dir;
        e_rwe = e_b &&  m_dir;
        k     = (m_c - 1) / 2;
        ea    = m_base + 12'(k);
        chk("busy",      busy,      m_active);
        chk("done",      done,      e_d);
        chk("mem_we",    mem_we,    e_mwe);
        chk("rf_we",     rf_we,     e_rwe);
        chk("u1_busy",   b1_busy,   m_active);
        chk("u1_done",   b1_done,   e_d);
        chk("u1_mem_we", b1_mem_we, e_mwe);
        chk("u1_rf_we",  b1_rf_we,  e_rwe);
        if (e_a && !m_dir) begin
          chk("rf_sel_out",    rf_sel_out,    k);
          chk("u1_rf_sel_out", b1_rf_sel_out, k);
        end
        if (e_a && m_dir) begin
          chk("load_mem_addr",    mem_addr,    ea);
          chk("u1_load_mem_addr", b1_mem_addr, ea);
        end
        if (e_mwe) begin
          chk("store_mem_addr",     mem_addr,     ea);
          chk("store_mem_wdata",    mem_wdata,    exp_rf[k]);
          chk("u1_store_mem_wdata", b1_mem_wdata, exp_rf[k]);
          exp_mem[ea] = exp_rf[k];
        end
        if (e_rwe) begin
          chk("load_rf_sel_in",  rf_sel_in,   k);
          chk("load_rf_wdata",   rf_wdata,    exp_mem[ea]);
          chk("u1_load_rf_wdata", b1_rf_wdata, exp_mem[ea]);
          exp_rf[k] = exp_mem[ea];
        end
        if (e_d) begin
          chk("i_next",    i_next,    12'(m_base + 12'(m_x) + 12'd1));
          chk("u1_i_next", b1_i_next, m_base);
        end
      end
    end
  end

  task automatic poke(input bit is_mem, input logic [11:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    pk_en = 1'b1; pk_mem = is_mem; pk_a = a; pk_d = d;
    @(posedge clk);
    #1;
    pk_en = 1'b0;
  endtask

  task automatic image_check();
    int bad = 0;
    for (int a = 0; a < 4096; a++) if (mem[a] != exp_mem[a]) bad++;
    for (int r = 0; r < 16; r++)   if (rf[r] != exp_rf[r]) bad++;
    chk("image_mismatches", bad, 0);
  endtask

  // One operation; optional noise pulses start with random arguments while
  // busy and always in the done cycle.
  task automatic run_op(input bit d, input logic [3:0] x, input logic [11:0] b,
                        input bit noise, output int dc, output int wcnt,
                        output logic [11:0] in0, output logic [11:0] in1);
    int n   = 0;
    bit got = 1'b0;
    dc = -1; wcnt = 0; in0 = '0; in1 = '0;
    @(negedge clk);
    start = 1'b1; dir = d; last_reg = x; base_addr = b;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (noise && ($urandom_range(0, 1) == 1)) begin
        start = 1'b1; dir = 1'($urandom); last_reg = 4'($urandom); base_addr = 12'($urandom);
      end
      if (mem_we || rf_we) wcnt++;
      if (done) begin
        got = 1'b1; dc = n; in0 = i_next; in1 = b1_i_next;
        if (noise) begin
          start = 1'b1; dir = ~d; last_reg = ~x; base_addr = ~b;
        end
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    if (start) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    int          dc, wc;
    logic [11:0] in0, in1;
    logic [7:0]  snap, v0;
    reset = 1'b0; start = 1'b0; dir = 1'b0; last_reg = '0; base_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_i_next", i_next, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rf_sel_out", rf_sel_out, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    reset = 1'b1;

    // Store V0..V3 to 0x300..0x303.
    poke(0, 0, 8'h11); poke(0, 1, 8'h22); poke(0, 2, 8'h33); poke(0, 3, 8'h44);
    poke(1, 12'h304, 8'h5A);
    run_op(0, 4'd3, 12'h300, 0, dc, wc, in0, in1);
    chk("store_done_cycle", dc, 9);
    chk("store_i_next", in0, 12'h304);
    chk("store_strobes", wc, 4);
    chk("store_mem300", mem[12'h300], 8'h11);
    chk("store_mem303", mem[12'h303], 8'h44);
    chk("store_mem304_untouched", mem[12'h304], 8'h5A);
    image_check();

    // Load V0 from 0x200.
    poke(1, 12'h200, 8'hA5); poke(0, 1, 8'h77);
    run_op(1, 4'd0, 12'h200, 0, dc, wc, in0, in1);
    chk("load_done_cycle", dc, 3);
    chk("load_i_next", in0, 12'h201);
    chk("load_strobes", wc, 1);
    chk("load_v0", rf[0], 8'hA5);
    chk("load_v1_untouched", rf[1], 8'h77);
    image_check();

    // Load all sixteen across the address wrap.
    for (int i = 0; i < 16; i++) poke(1, 12'hFF8 + 12'(i), 8'(i));
    run_op(1, 4'd15, 12'hFF8, 0, dc, wc, in0, in1);
    chk("wrap_done_cycle", dc, 33);
    chk("wrap_i_next", in0, 12'h008);
    chk("wrap_strobes", wc, 16);
    for (int i = 0; i < 16; i++) chk("wrap_vn", rf[i], i);
    image_check();

    // Starts while busy and in the done cycle are ignored.
    run_op(0, 4'd5, 12'h400, 1, dc, wc, in0, in1);
    chk("busy_done_cycle", dc, 13);
    chk("busy_strobes", wc, 6);
    chk("busy_i_next", in0, 12'h406);
    repeat (2) @(negedge clk);
    chk("busy_idle_after", busy, 0);
    image_check();

    // Reset during cycle 4 of an x=7 store aborts it.
    v0 = 8'($urandom);
    poke(0, 0, v0);
    poke(1, 12'h101, 8'hC3);
    snap = mem[12'h101];
    @(negedge clk);
    start = 1'b1; dir = 1'b0; last_reg = 4'd7; base_addr = 12'h100;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_mem_we", mem_we, 0);
    chk("abort_rf_we", rf_we, 0);
    chk("abort_i_next", i_next, 0);
    chk("abort_mem_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("abort_mem100_written", mem[12'h100], v0);
    chk("abort_mem101_untouched", mem[12'h101], snap);
    image_check();

    // Unchanged-I instance on a store of three registers.
    run_op(0, 4'd2, 12'h050, 0, dc, wc, in0, in1);
    chk("noinc_i_next", in1, 12'h050);
    chk("noinc_done_cycle", dc, 7);
    chk("inc_i_next", in0, 12'h053);
    image_check();

    // Randomized operations.
    for (int t = 0; t < 25; t++) begin : rnd
      bit          d;
      logic [3:0]  x;
      logic [11:0] b;
      d = 1'($urandom);
      x = 4'($urandom);
      b = 12'($urandom);
      for (int p = 0; p < 4; p++) begin
        poke(1, b + 12'($urandom_range(0, 15)), 8'($urandom));
        poke(0, 12'($urandom_range(0, 15)), 8'($urandom));
      end
      run_op(d, x, b, 1'($urandom), dc, wc, in0, in1);
      chk("rnd_done_cycle", dc, 2 * int'(x) + 3);
      chk("rnd_strobes", wc, int'(x) + 1);
      image_check();
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_block_transfer.md
Name: regfile_block_transfer

Overview:
- Sequencer for the CHIP-8 block register/memory transfer opcodes FX55 and FX65.
- FX55 stores V0..Vx to mem[I..I+x]. FX65 loads V0..Vx from mem[I..I+x].
- Drives the V0..VF register file through its write port and its output1 read port.
- Drives the main memory port. The instruction decoder starts it and stalls until `done`.

Parameters:
- ADDR_WIDTH, 12: memory address width. Address arithmetic wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 8: register and memory data width.
- INCREMENT_I, 1: selects the value reported on `i_next`.
  - 1: `i_next` = base_addr + x + 1 (original COSMAC behaviour).
  - 0: `i_next` = base_addr (I unchanged).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request. Sampled only in IDLE.
- dir  in  1  0 = store (reg->mem, FX55), 1 = load (mem->reg, FX65). Sampled with start.
- last_reg  in  4  x: highest register index transferred, 0..15. Sampled with start.
- base_addr  in  ADDR_WIDTH  I register value. Sampled with start.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle inclusive.
- done  out  1  one-cycle pulse at completion.
- i_next  out  ADDR_WIDTH  new I value. Valid while done=1 and held until the next accepted start.
- rf_sel_out  out  4  register file read select (output1 port).
- rf_rdata  in  DATA_WIDTH  register file output1 data. Valid one cycle after rf_sel_out.
- rf_we  out  1  register file write enable.
- rf_sel_in  out  4  register file write select.
- rf_wdata  out  DATA_WIDTH  register file write data.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data. Valid one cycle after mem_addr (synchronous RAM).

Behaviour:
- State machine: IDLE, XFER_A, XFER_B, DONE. Internal 4-bit counter k, plus latched dir, x and base.

- Reset (reset=0, asynchronous):
  - State goes to IDLE and k=0.
  - All outputs go to 0: busy, done, i_next, rf_we, rf_sel_in, rf_wdata, rf_sel_out, mem_addr, mem_we, mem_wdata.
  - A reset asserted mid-transfer aborts the transfer. No write strobe is issued after reset asserts. Writes already completed are not undone.

- IDLE:
  - If start=1 at a rising edge: latch dir, x and base; set k=0; go to XFER_A.
  - Otherwise stay in IDLE. All strobes are 0.

- XFER_A (one cycle):
  - Store: rf_sel_out=k.
  - Load: mem_addr = base+k.
  - rf_we=0 and mem_we=0.
  - Next state is XFER_B.

- XFER_B (one cycle):
  - Store: mem_we=1, mem_addr=base+k, mem_wdata=rf_rdata.
  - Load: rf_we=1, rf_sel_in=k, rf_wdata=mem_rdata.
  - If k==x, go to DONE. Otherwise k=k+1 and go to XFER_A.

- DONE (one cycle):
  - done=1, busy=1 and i_next is updated.
  - Next state is IDLE.

- Address arithmetic: base+k is computed at ADDR_WIDTH bits and wraps (0xFFF+1 = 0x000). i_next wraps the same way.

- Latency: with the accept edge counted as cycle 0, XFER occupies cycles 1..2(x+1), done is high in cycle 2(x+1)+1, and IDLE is re-entered on the next edge. At x=15 that is 32 transfer cycles and done in cycle 33.

- Input stability: start is ignored while busy=1. Changes to dir, last_reg or base_addr during busy have no effect. A start in the same cycle as done is ignored; a new start is accepted only in IDLE.

- Strobe integrity: exactly one write strobe per register (x+1 total) per operation. rf_we and mem_we are never high together and are never high outside XFER_B.

- Output values: addresses and select lines hold their last values when not in use. Strobes are 0 outside XFER_B.

Test Plan:
- Store: V0..V3 = 0x11,0x22,0x33,0x44; start with dir=0, x=3, base=0x300 -> mem[0x300..0x303] = 0x11,0x22,0x33,0x44; mem[0x304] untouched; done in cycle 9; i_next=0x304.
- Load: mem[0x200]=0xA5; start with dir=1, x=0, base=0x200 -> V0=0xA5; V1..VF unchanged; exactly one rf_we pulse; done in cycle 3; i_next=0x201.
- Wrap: dir=1, x=15, base=0xFF8, mem[0xFF8..0xFFF,0x000..0x007] = 0..15 -> Vn=n; done in cycle 33; i_next=0x008.
- Busy: start pulsed again with different args while busy, and again in the done cycle -> both ignored; memory and register writes match the first operation only.
- Reset: reset=0 asserted in cycle 4 of an x=7 store -> strobes drop immediately, busy=0, done never pulses; the next start after release executes normally.
- INCREMENT_I=0: store with x=2, base=0x050 -> i_next=0x050 at done.
